// File: rtl/lighting_system_if.sv
// Lighting/shade controller bus.
// Groups the per-cycle sampled inputs (tcode, ulight, lenght) and the
// registered outputs (wshade, lightnum, lightstate) of lighting_system.
//   master : drives tcode/ulight/lenght, observes the outputs (home controller)
//   slave  : the lighting_system block itself
interface lighting_system_if;
    logic [3:0]  tcode;       // one-hot time of day, 0000 = night
    logic [3:0]  ulight;      // user-requested lamp count
    logic [3:0]  lenght;      // window length in shade steps
    logic [3:0]  wshade;      // shade extension
    logic [3:0]  lightnum;    // general lamps currently on
    logic [15:0] lightstate;  // [14:0] general lamps, [15] night lamp

    modport master (
        output tcode, ulight, lenght,
        input  wshade, lightnum, lightstate
    );

    modport slave (
        input  tcode, ulight, lenght,
        output wshade, lightnum, lightstate
    );
endinterface

// File: rtl/lighting_system.sv
// Smart-home lighting and window-shade controller.
// Every clock the time-of-day code is decoded into a daylight credit and a
// shade setting. The shade output follows the setting with one cycle of
// latency; the lamp count ramps one step per clock toward
// (ulight - credit, floored at 0) and is expanded into a lamp-enable vector.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset; clears all outputs at once
//   bus  : lighting_system_if.slave (tcode/ulight/lenght in,
//          wshade/lightnum/lightstate out, all outputs registered)
module lighting_system (
    input  logic               clk,
    input  logic               rst,
    lighting_system_if.slave   bus
);

    // Decoded per-period settings.
    typedef struct packed {
        logic       night;   // drives the night lamp
        logic [3:0] credit;  // lamps subtracted from the user request
        logic [3:0] shade;   // shade extension for this period
    } period_t;

    period_t     per;
    logic [3:0]  target;
    logic [3:0]  num_next;
    logic [15:0] therm;
    logic [15:0] state_next;

    logic [3:0]  wshade_q;
    logic [3:0]  lightnum_q;
    logic [15:0] lightstate_q;

    // Period decode. Anything that is not exactly one of the four one-hot
    // codes falls back to night, so a glitched code keeps the shade closed
    // and the night lamp lit rather than opening up.
    always_comb begin
        per = '{night: 1'b1, credit: 4'd0, shade: bus.lenght};
        case (bus.tcode)
            4'b0001: per = '{night: 1'b0, credit: 4'd4,  shade: bus.lenght >> 1};
            4'b0010: per = '{night: 1'b0, credit: 4'd8,  shade: 4'd0};
            4'b0100: per = '{night: 1'b0, credit: 4'd12, shade: bus.lenght >> 1};
            4'b1000: per = '{night: 1'b0, credit: 4'd4,  shade: bus.lenght};
            default: per = '{night: 1'b1, credit: 4'd0,  shade: bus.lenght};
        endcase
    end

    // Saturating subtract: a bright period never wraps the target around.
    always_comb begin
        target = 4'd0;
        if (bus.ulight > per.credit)
            target = bus.ulight - per.credit;
    end

    // One step per clock toward the current target; a target change mid-ramp
    // simply redirects the next step.
    always_comb begin
        num_next = lightnum_q;
        if (lightnum_q < target)
            num_next = lightnum_q + 4'd1;
        else if (lightnum_q > target)
            num_next = lightnum_q - 4'd1;
    end

    // Thermometer of the updated count so lightstate and lightnum leave the
    // same edge consistent. num_next <= 15, so bit 15 of therm is always 0
    // and only [14:0] is used for the general lamps.
    always_comb begin
        therm      = (16'd1 << num_next) - 16'd1;
        state_next = {per.night, therm[14:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wshade_q     <= 4'd0;
            lightnum_q   <= 4'd0;
            lightstate_q <= 16'h0000;
        end else begin
            wshade_q     <= per.shade;
            lightnum_q   <= num_next;
            lightstate_q <= state_next;
        end
    end

    assign bus.wshade     = wshade_q;
    assign bus.lightnum   = lightnum_q;
    assign bus.lightstate = lightstate_q;

endmodule

// File: tb/tb_lighting_system.sv
// Directed bench for lighting_system: steps through the period sequence with
// hand-computed shade, lamp-count and lamp-enable values, including the
// asynchronous reset, underflow floor, invalid codes and shade truncation.
module tb_lighting_system;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    lighting_system_if bus ();

    lighting_system dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expect the lamp count to walk one step per clock from 'from' to 'to',
    // then hold for one more clock.
    task automatic ramp(input string tag, input int from, input int to);
        int cur;
        cur = from;
        while (cur != to) begin
            cur = (cur < to) ? cur + 1 : cur - 1;
            tick();
            chk(tag, 32'(bus.lightnum), 32'(cur));
        end
        tick();
        chk({tag, "_hold"}, 32'(bus.lightnum), 32'(to));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        bus.tcode  = 4'b0000;
        bus.ulight = 4'd10;
        bus.lenght = 4'd9;

        // Reset takes effect before the first clock edge (t=5).
        #2 rst = 1'b1;
        #1;
        chk("rst_wshade",     32'(bus.wshade),     32'd0);
        chk("rst_lightnum",   32'(bus.lightnum),   32'd0);
        chk("rst_lightstate", 32'(bus.lightstate), 32'h0000);
        tick();
        tick();
        chk("rst_hold_num",   32'(bus.lightnum),   32'd0);

        // Night, ulight=10: shade fully closed, ramp 1..10.
        rst = 1'b0;
        tick();
        chk("night_wshade", 32'(bus.wshade),   32'd9);
        chk("night_first",  32'(bus.lightnum), 32'd1);
        ramp("night_ramp", 1, 10);
        chk("night_state", 32'(bus.lightstate), 32'h83FF);

        // Dawn: target 6, half shade.
        bus.tcode = 4'b0001;
        ramp("dawn_ramp", 10, 6);
        chk("dawn_wshade", 32'(bus.wshade),     32'd4);
        chk("dawn_state",  32'(bus.lightstate), 32'h003F);

        // Morning: target 2, shade open.
        bus.tcode = 4'b0010;
        ramp("morn_ramp", 6, 2);
        chk("morn_wshade", 32'(bus.wshade),     32'd0);
        chk("morn_state",  32'(bus.lightstate), 32'h0003);

        // Noon: credit exceeds request, target floors at 0.
        bus.tcode = 4'b0100;
        ramp("noon_ramp", 2, 0);
        chk("noon_wshade", 32'(bus.wshade),     32'd4);
        chk("noon_state",  32'(bus.lightstate), 32'h0000);
        bus.ulight = 4'd3;
        tick();
        tick();
        chk("noon_floor", 32'(bus.lightnum), 32'd0);

        // Evening, ulight=3: still floored, then ulight=5 gives target 1.
        bus.tcode = 4'b1000;
        tick();
        chk("eve_wshade", 32'(bus.wshade),     32'd9);
        chk("eve_num",    32'(bus.lightnum),   32'd0);
        chk("eve_state0", 32'(bus.lightstate), 32'h0000);
        bus.ulight = 4'd5;
        tick();
        chk("eve_num1",   32'(bus.lightnum),   32'd1);
        chk("eve_state1", 32'(bus.lightstate), 32'h0001);

        // Back to night: target 5, night lamp on.
        bus.tcode = 4'b0000;
        ramp("night2_ramp", 1, 5);
        chk("night2_state", 32'(bus.lightstate), 32'h801F);

        // Invalid code behaves as night.
        bus.tcode  = 4'b0011;
        bus.ulight = 4'd15;
        bus.lenght = 4'd15;
        ramp("inv_ramp", 5, 15);
        chk("inv_wshade", 32'(bus.wshade),     32'd15);
        chk("inv_state",  32'(bus.lightstate), 32'hFFFF);

        // Ramp down, then reset mid-ramp between clock edges.
        bus.ulight = 4'd0;
        tick();
        tick();
        tick();
        chk("down_num", 32'(bus.lightnum), 32'd12);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wshade",     32'(bus.wshade),     32'd0);
        chk("mid_rst_lightnum",   32'(bus.lightnum),   32'd0);
        chk("mid_rst_lightstate", 32'(bus.lightstate), 32'h0000);
        tick();
        rst = 1'b0;
        bus.ulight = 4'd15;
        tick();
        chk("restart_num",    32'(bus.lightnum),   32'd1);
        chk("restart_state",  32'(bus.lightstate), 32'h8001);
        chk("restart_wshade", 32'(bus.wshade),     32'd15);

        // Shade boundaries.
        bus.lenght = 4'd1;
        bus.tcode  = 4'b0001;
        tick();
        chk("dawn_len1", 32'(bus.wshade), 32'd0);
        bus.tcode  = 4'b0100;
        tick();
        chk("noon_len1", 32'(bus.wshade), 32'd0);
        bus.tcode  = 4'b1000;
        tick();
        chk("eve_len1", 32'(bus.wshade), 32'd1);
        bus.lenght = 4'd0;
        bus.tcode  = 4'b0000;
        tick();
        chk("night_len0", 32'(bus.wshade), 32'd0);
        bus.tcode  = 4'b1000;
        tick();
        chk("eve_len0", 32'(bus.wshade), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
